// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Bytewise program loader. It takes a valid/ready byte stream from a host or
// serial front end and writes a program image into the RAM program-load port.
// The CPU is held in reset while the image is written and released when the
// frame completes.
//
// Frame: header byte, then N data bytes, then an optional checksum byte.
//   header[7:4] = start address A, header[3:0] = N-1 (N = 1..16).
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : a trailing checksum byte (8-bit sum of the data bytes) is
//               expected; on mismatch `error` is set and the CPU stays held.
//   undefined : no checksum byte, no accumulator, `error` tied to 0.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   s_valid        in   host byte valid
//   s_data         in   host byte (DATA_W)
//   s_ready        out  loader can accept a byte (combinational state decode)
//   input_mode     out  RAM write strobe, one cycle per data byte
//   input_address  out  RAM write address (ADDR_W)
//   input_program  out  RAM write data (DATA_W)
//   cpu_reset      out  active-low CPU reset; 0 holds the CPU
//   busy           out  a frame is in progress
//   done           out  one-cycle pulse when the CPU is released
//   error          out  sticky checksum failure, cleared by the next header
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              input_mode,
  output logic [ADDR_W-1:0] input_address,
  output logic [DATA_W-1:0] input_program,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DATA    = 3'd1;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK     = 3'd2;
`endif
  // DRAIN lets the final RAM write retire before RELEASE, so the CPU is
  // released two edges after the last accepted byte and never while a write
  // strobe is still high.
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] addr_cnt_r;
  logic [3:0]        remain_r;
  logic              input_mode_r;
  logic [ADDR_W-1:0] input_address_r;
  logic [DATA_W-1:0] input_program_r;
  logic              cpu_reset_r;
  logic              busy_r;
  logic              done_r;
  logic              s_ready_s;
  logic              xfer_s;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] acc_r;
  logic              error_r;
`endif

  // Ready decode: accepting states only, and never while reset is asserted.
  always_comb begin
    s_ready_s = 1'b0;
    case (state_r)
      ST_IDLE:  s_ready_s = reset;
      ST_DATA:  s_ready_s = reset;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:   s_ready_s = reset;
`endif
      default:  s_ready_s = 1'b0;
    endcase
  end

  assign xfer_s = s_valid && s_ready_s;

  // Frame FSM, address/count tracking, RAM write port and CPU reset control.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      addr_cnt_r      <= {ADDR_W{1'b0}};
      remain_r        <= 4'd0;
      input_mode_r    <= 1'b0;
      input_address_r <= {ADDR_W{1'b0}};
      input_program_r <= {DATA_W{1'b0}};
      cpu_reset_r     <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc_r           <= {DATA_W{1'b0}};
      error_r         <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      input_mode_r <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (xfer_s) begin
            addr_cnt_r  <= ADDR_W'(s_data[7:4]);
            remain_r    <= s_data[3:0];
            cpu_reset_r <= 1'b0;   // also re-holds the CPU on a reload
            busy_r      <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            acc_r       <= {DATA_W{1'b0}};
            error_r     <= 1'b0;
`endif
            state_r     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            input_mode_r    <= 1'b1;
            input_address_r <= addr_cnt_r;
            input_program_r <= s_data;
            addr_cnt_r      <= addr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            remain_r        <= remain_r - 4'd1;
`ifdef LOADER_CHECKSUM_EN
            acc_r           <= acc_r + s_data;
`endif
            if (remain_r == 4'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_r <= ST_CHK;
`else
              state_r <= ST_DRAIN;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer_s) begin
            if (s_data == acc_r) begin
              state_r <= ST_DRAIN;
            end else begin
              // Bad image: keep the CPU held and report.
              error_r <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end
`endif
        ST_DRAIN: begin
          state_r <= ST_RELEASE;
        end
        ST_RELEASE: begin
          cpu_reset_r <= 1'b1;
          done_r      <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready       = s_ready_s;
  assign input_mode    = input_mode_r;
  assign input_address = input_address_r;
  assign input_program = input_program_r;
  assign cpu_reset     = cpu_reset_r;
  assign busy          = busy_r;
  assign done          = done_r;
`ifdef LOADER_CHECKSUM_EN
  assign error         = error_r;
`else
  assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Scoreboard bench for program_loader. The driver sends frames built from a
// reference model (write address = (A + i) mod 16, checksum = sum mod 256)
// and pushes the expected RAM writes and release cycles into queues; a
// separate monitor pops and compares whenever the DUT strobes a write or
// pulses done. Works with or without LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       input_mode;
  logic [3:0] input_address;
  logic [7:0] input_program;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;

  program_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .input_mode    (input_mode),
    .input_address (input_address),
    .input_program (input_program),
    .cpu_reset     (cpu_reset),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_q[$];
  int         done_q[$];
  logic [7:0] fdata[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Monitor: pop the scoreboard whenever the DUT writes RAM or releases the CPU.
  wr_t mon_e;
  int  mon_c;
  always @(negedge clk) begin
    if (reset) begin
      if (input_mode) begin
        if (wr_q.size() == 0) fail("unexpected_write");
        else begin
          mon_e = wr_q.pop_front();
          check("wr_addr", 32'(input_address), 32'(mon_e.a));
          check("wr_data", 32'(input_program), 32'(mon_e.d));
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail("unexpected_done");
        else begin
          mon_c = done_q.pop_front();
          check("done_cycle", mon_c, cyc);
          check("done_cpu_reset", 32'(cpu_reset), 32'd1);
          check("done_no_write", 32'(input_mode), 32'd0);
        end
      end
    end
  end

  // Present one byte (after an optional idle gap) and wait, bounded, for accept.
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
    logic rdy;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    acc_cyc = -1;
    for (int t = 0; t < 50 && acc_cyc < 0; t++) begin
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) acc_cyc = cyc;
      else @(negedge clk);
    end
    if (acc_cyc < 0) fail("accept_timeout");
  endtask

  // Send one frame with data taken from fdata. bad != 0 corrupts the checksum
  // by adding bad to the correct sum (checksum builds only).
  task automatic send_frame(input logic [7:0] hdr, input int bad, input int gapmax);
    int         n;
    int         a;
    int         acc;
    logic [7:0] sum;
    logic [7:0] cb;
    n   = int'(hdr[3:0]) + 1;
    a   = int'(hdr[7:4]);
    sum = 8'h00;
    send_byte(hdr, $urandom_range(gapmax, 0), acc);
    check("hdr_busy", 32'(busy), 32'd1);
    check("hdr_cpu_reset", 32'(cpu_reset), 32'd0);
    check("hdr_error", 32'(error), 32'd0);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back({4'((a + i) % 16), fdata[i]});
      sum = sum + fdata[i];
      send_byte(fdata[i], $urandom_range(gapmax, 0), acc);
    end
`ifdef LOADER_CHECKSUM_EN
    cb = sum + 8'(bad);
    send_byte(cb, $urandom_range(gapmax, 0), acc);
`else
    cb = sum;
    bad = 0;
`endif
    if (bad == 0) done_q.push_back(acc + 2);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("end_cpu_reset", 32'(cpu_reset), (bad == 0) ? 32'd1 : 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_error", 32'(error), (bad == 0) ? 32'd0 : 32'd1);
    check("end_s_ready", 32'(s_ready), 32'd1);
  endtask

  int acc_d;

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_input_mode", 32'(input_mode), 32'd0);
    check("rst_input_address", 32'(input_address), 32'd0);
    check("rst_input_program", 32'(input_program), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_release_s_ready", 32'(s_ready), 32'd1);

    // Basic load at 9..B, continuous valid.
    fdata[0] = 8'h01; fdata[1] = 8'h08; fdata[2] = 8'h79;
    send_frame(8'h92, 0, 0);

    // Address wrap F -> 0 (also a reload after a good load).
    fdata[0] = 8'hAA; fdata[1] = 8'hBB;
    send_frame(8'hF1, 0, 0);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum, then bad checksum (0x31), then a good frame clears error.
    fdata[0] = 8'h10; fdata[1] = 8'h20;
    send_frame(8'h01, 0, 0);
    send_frame(8'h01, 1, 0);
    send_frame(8'h01, 0, 1);
`endif

    // Stall mid-frame, then abort with reset.
    fdata[0] = 8'h5C;
    send_byte(8'h03, 0, acc_d);
    wr_q.push_back({4'h0, 8'h5C});
    send_byte(8'h5C, 0, acc_d);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_no_write", 32'(input_mode), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_input_mode", 32'(input_mode), 32'd0);
    check("abort_cpu_reset", 32'(cpu_reset), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_s_ready", 32'(s_ready), 32'd1);
    check("abort_busy_after", 32'(busy), 32'd0);

    // Randomized frames with random gaps and occasional bad checksums.
    for (int f = 0; f < 40; f++) begin
      logic [7:0] hdr;
      int         bad;
      hdr = 8'($urandom_range(255, 0));
      for (int i = 0; i < 16; i++) fdata[i] = 8'($urandom_range(255, 0));
      bad = ($urandom_range(3, 0) == 0) ? $urandom_range(255, 1) : 0;
      send_frame(hdr, bad, 2);
    end

    repeat (5) @(negedge clk);
    check("writes_all_seen", wr_q.size(), 32'd0);
    check("dones_all_seen", done_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
